seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 226 ++++++++++++++++++++++
 tb/tb_seq_alu.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle arithmetic/logic ops plus iterative restoring divide.
// Define SEQ_ALU_MUL_EN to add an iterative shift-add multiplier; otherwise MUL is illegal.

package seq_alu_pkg;
    typedef enum logic [4:0] {
        OP_ADD = 5'd0,
        OP_SUB = 5'd1,
        OP_SLL = 5'd2,
        OP_SRL = 5'd3,
        OP_AND = 5'd4,
        OP_SEQ = 5'd5,
        OP_MOD = 5'd6,
        OP_DIV = 5'd7,
        OP_MUL = 5'd8
    } op_e;
endpackage

module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_carry,
    output logic             illegal_op
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;
    typedef enum logic [1:0] {M_DIV, M_MOD, M_MUL} mode_e;

    state_e             r_state, w_state_nxt;
    mode_e              r_mode, w_mode_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [WIDTH-1:0]   r_rem, w_rem_nxt;
    logic [WIDTH-1:0]   r_quo, w_quo_nxt;
    logic [WIDTH-1:0]   r_dvs, w_dvs_nxt;
    logic [WIDTH-1:0]   r_result, w_result_nxt;
    logic               r_zero, w_zero_nxt;
    logic               r_carry, w_carry_nxt;
    logic               r_illegal, w_illegal_nxt;
    logic               r_in_ready, w_in_ready_nxt;
    logic               r_out_valid, w_out_valid_nxt;
`ifdef SEQ_ALU_MUL_EN
    logic [WIDTH-1:0]   r_mcand, w_mcand_nxt;
    logic [WIDTH:0]     w_mul_sum;
`endif

    logic [WIDTH:0]     w_sum, w_dif;
    logic [SHAMT_W-1:0] w_shamt;
    logic               w_shift_ovf;
    logic [WIDTH-1:0]   w_res_c;
    logic [WIDTH:0]     w_rem_shift;
    logic               w_ge;
    logic [WIDTH-1:0]   w_step_rem, w_step_quo;

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign result     = r_result;
    assign flag_zero  = r_zero;
    assign flag_carry = r_carry;
    assign illegal_op = r_illegal;

    // Single-cycle datapath, evaluated on the live operands at acceptance
    assign w_sum       = (WIDTH+1)'(a) + (WIDTH+1)'(b);
    assign w_dif       = (WIDTH+1)'(a) - (WIDTH+1)'(b);
    assign w_shamt     = b[SHAMT_W-1:0];
    assign w_shift_ovf = (b >> SHAMT_W) != '0;

    // One iteration: restoring-divide step, or shift-add step when multiplying
    always_comb begin
        w_rem_shift = {r_rem, r_quo[WIDTH-1]};
        w_ge        = w_rem_shift >= (WIDTH+1)'(r_dvs);
        w_step_rem  = w_ge ? WIDTH'(w_rem_shift - (WIDTH+1)'(r_dvs)) : WIDTH'(w_rem_shift);
        w_step_quo  = {r_quo[WIDTH-2:0], w_ge};
`ifdef SEQ_ALU_MUL_EN
        w_mul_sum   = (WIDTH+1)'(r_rem) + (WIDTH+1)'(r_quo[0] ? r_mcand : '0);
        if (r_mode == M_MUL) begin
            w_step_rem = w_mul_sum[WIDTH:1];
            w_step_quo = {w_mul_sum[0], r_quo[WIDTH-1:1]};
        end
`endif
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_mode_nxt    = r_mode;
        w_cnt_nxt     = r_cnt;
        w_rem_nxt     = r_rem;
        w_quo_nxt     = r_quo;
        w_dvs_nxt     = r_dvs;
        w_result_nxt  = r_result;
        w_zero_nxt    = r_zero;
        w_carry_nxt   = r_carry;
        w_illegal_nxt = r_illegal;
        w_res_c       = '0;
`ifdef SEQ_ALU_MUL_EN
        w_mcand_nxt   = r_mcand;
`endif
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt   = S_DONE;
                    w_carry_nxt   = 1'b0;
                    w_illegal_nxt = 1'b0;
                    case (op)
                        OP_ADD: begin
                            w_res_c     = w_sum[WIDTH-1:0];
                            w_carry_nxt = w_sum[WIDTH];
                        end
                        OP_SUB: begin
                            w_res_c     = w_dif[WIDTH-1:0];
                            w_carry_nxt = w_dif[WIDTH];
                        end
                        OP_SLL: w_res_c = w_shift_ovf ? '0 : (a << w_shamt);
                        OP_SRL: w_res_c = w_shift_ovf ? '0 : (a >> w_shamt);
                        OP_AND: w_res_c = a & b;
                        OP_SEQ: w_res_c = WIDTH'(a == b);
                        OP_DIV, OP_MOD: begin
                            if (b == '0) begin
                                w_res_c = (op == OP_DIV) ? '1 : a;
                            end else begin
                                w_state_nxt = S_ITER;
                                w_mode_nxt  = (op == OP_DIV) ? M_DIV : M_MOD;
                                w_cnt_nxt   = '0;
                                w_rem_nxt   = '0;
                                w_quo_nxt   = a;
                                w_dvs_nxt   = b;
                            end
                        end
`ifdef SEQ_ALU_MUL_EN
                        OP_MUL: begin
                            w_state_nxt = S_ITER;
                            w_mode_nxt  = M_MUL;
                            w_cnt_nxt   = '0;
                            w_rem_nxt   = '0;
                            w_quo_nxt   = b;
                            w_mcand_nxt = a;
                        end
`endif
                        default: w_illegal_nxt = 1'b1;
                    endcase
                    w_result_nxt = w_res_c;
                    w_zero_nxt   = (w_res_c == '0);
                end
            end
            S_ITER: begin
                w_rem_nxt = w_step_rem;
                w_quo_nxt = w_step_quo;
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == CNT_W'(WIDTH-1)) begin
                    w_state_nxt   = S_DONE;
                    w_illegal_nxt = 1'b0;
                    w_carry_nxt   = 1'b0;
                    case (r_mode)
                        M_MOD:   w_res_c = w_step_rem;
                        M_MUL: begin
                            w_res_c     = w_step_quo;
                            w_carry_nxt = |w_step_rem;
                        end
                        default: w_res_c = w_step_quo;
                    endcase
                    w_result_nxt = w_res_c;
                    w_zero_nxt   = (w_res_c == '0);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
        w_in_ready_nxt  = (w_state_nxt == S_IDLE);
        w_out_valid_nxt = (w_state_nxt == S_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_mode      <= M_DIV;
            r_cnt       <= '0;
            r_rem       <= '0;
            r_quo       <= '0;
            r_dvs       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_carry     <= 1'b0;
            r_illegal   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
            r_mcand     <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_mode      <= w_mode_nxt;
            r_cnt       <= w_cnt_nxt;
            r_rem       <= w_rem_nxt;
            r_quo       <= w_quo_nxt;
            r_dvs       <= w_dvs_nxt;
            r_result    <= w_result_nxt;
            r_zero      <= w_zero_nxt;
            r_carry     <= w_carry_nxt;
            r_illegal   <= w_illegal_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_out_valid <= w_out_valid_nxt;
`ifdef SEQ_ALU_MUL_EN
            r_mcand     <= w_mcand_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, reset abort, and random ops
// checked against an arithmetic reference model.

module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int unsigned W   = 8;
    localparam int unsigned SHW = 3;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [4:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_zero;
    logic         flag_carry;
    logic         illegal_op;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    seq_alu #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_zero  (flag_zero),
        .flag_carry (flag_carry),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour straight from the operation definitions
    function automatic void model(input logic [4:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic c, output logic il,
                                  output int lat);
        longint unsigned xa, ya, t;
        xa = x; ya = y; t = 0;
        r = '0; c = 1'b0; il = 1'b0; lat = 1;
        case (o)
            OP_ADD: begin t = xa + ya; r = W'(t); c = (t >> W) != 0; end
            OP_SUB: begin r = W'(xa - ya); c = (xa < ya); end
            OP_SLL: r = (ya >= (64'd1 << SHW)) ? '0 : W'(xa << ya);
            OP_SRL: r = (ya >= (64'd1 << SHW)) ? '0 : W'(xa >> ya);
            OP_AND: r = x & y;
            OP_SEQ: r = W'(x == y);
            OP_MOD: if (y == 0) r = x; else begin r = W'(xa % ya); lat = W + 1; end
            OP_DIV: if (y == 0) r = '1; else begin r = W'(xa / ya); lat = W + 1; end
`ifdef SEQ_ALU_MUL_EN
            OP_MUL: begin t = xa * ya; r = W'(t); c = (t >> W) != 0; lat = W + 1; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string tag, input logic [4:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input int hold);
        logic [W-1:0] er;
        logic         ec;
        logic         eil;
        int           elat;
        int           lat;
        model(o, x, y, er, ec, eil, elat);
        check({tag, " in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'(($urandom) & 1);
        op = 5'($urandom); a = W'($urandom); b = W'($urandom);
        lat = 1;
        while (!out_valid && lat < 4 * W) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'(elat));
        check({tag, " result"}, 32'(result), 32'(er));
        check({tag, " zero"}, 32'(flag_zero), 32'(er == '0));
        check({tag, " carry"}, 32'(flag_carry), 32'(ec));
        check({tag, " illegal"}, 32'(illegal_op), 32'(eil));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check({tag, " hold_valid"}, 32'({out_valid, in_ready}), 32'b10);
            check({tag, " hold_result"}, 32'({result, flag_zero, flag_carry}),
                  32'({er, (er == '0), ec}));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check({tag, " release"}, 32'({in_ready, out_valid}), 32'b10);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({in_ready, out_valid, result, flag_zero, flag_carry, illegal_op}),
              32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_idle", 32'({in_ready, out_valid}), 32'b10);

        run_op("add_f0_20", OP_ADD, 8'hF0, 8'h20, 0);
        run_op("div_200_7", OP_DIV, 8'd200, 8'd7, 0);
        run_op("mod_200_7", OP_MOD, 8'd200, 8'd7, 1);
        run_op("div_55_0", OP_DIV, 8'd55, 8'd0, 0);
        run_op("mod_55_0", OP_MOD, 8'd55, 8'd0, 0);
        run_op("sll_81_3", OP_SLL, 8'h81, 8'd3, 0);
        run_op("srl_81_10", OP_SRL, 8'h81, 8'h10, 0);
        run_op("sub_5_5_bp", OP_SUB, 8'd5, 8'd5, 4);
        run_op("sub_borrow", OP_SUB, 8'd3, 8'd9, 0);
        run_op("seq_eq", OP_SEQ, 8'h5A, 8'h5A, 0);
        run_op("illegal_op", 5'd20, 8'h12, 8'h34, 0);

        // Abort a divide mid-iteration with reset
        in_valid = 1'b1; op = OP_DIV; a = 8'd200; b = 8'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_div", 32'({in_ready, out_valid, result, flag_zero, flag_carry, illegal_op}),
              32'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0}));
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            seen = seen | out_valid | ~in_ready;
        end
        check("rst_mid_div_no_result", 32'(seen), 32'd0);

        run_op("mul_16_17", OP_MUL, 8'd16, 8'd17, 0);

        for (int n = 0; n < 60; n++) begin
            logic [4:0]   ro;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ro = 5'($urandom_range(0, 11));
            ra = W'($urandom);
            rb = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 9)) : W'($urandom);
            run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb, $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
